memory_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline, between EX and WB: holds the EX/MEM latch (execute_t), issues the

---
 rtl/custom_types_pkg.sv | 46 ++++
 rtl/branch_resolve.sv | 33 +++
 rtl/memory_stage.sv | 118 +++++++++++
 tb/tb_memory_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/custom_types_pkg.sv
// Shared pipeline types: EX/MEM and MEM/WB latch layouts, MEM FSM states and
// the encodings of the jump-select and memory-to-register fields.
package custom_types_pkg;

  localparam logic [1:0] JSEL_SEQ = 2'b00;
  localparam logic [1:0] JSEL_J   = 2'b01;
  localparam logic [1:0] JSEL_JR  = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_NPC = 2'd2;
  localparam logic [1:0] MTR_IMM = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} mem_state_t;

  typedef struct packed {
    logic [4:0]  Rw;
    logic        RegWEN;
    logic [1:0]  MemtoReg;
    logic        halt;
    logic [31:0] NPC;
    logic [31:0] port_o;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [31:0] Imm_Ext;
    logic [31:0] JumpAddr;
    logic [1:0]  JumpSel;
    logic        BEQ;
    logic        BNE;
    logic        zero;
    logic        dREN;
    logic        dWEN;
  } execute_t;

  typedef struct packed {
    logic [4:0]  Rw;
    logic        RegWEN;
    logic [1:0]  MemtoReg;
    logic        halt;
    logic [31:0] NPC;
    logic [31:0] port_o;
    logic [31:0] Imm_Ext;
    logic [31:0] dmemload;
  } memory_t;

endpackage

// File: rtl/branch_resolve.sv
// Decides whether the instruction in the EX/MEM latch changes control flow
// and where to. Validity and halt gating are applied by the caller.
import custom_types_pkg::*;

module branch_resolve (
  input  execute_t    ex,
  output logic        redirect,
  output logic [31:0] target
);

  logic unusedFields;
  assign unusedFields = &{1'b0, ex.Rw, ex.RegWEN, ex.MemtoReg, ex.halt,
                          ex.port_o, ex.port_b, ex.dREN, ex.dWEN};

  always_comb begin
    redirect = 1'b0;
    // Word-offset branch relative to NPC; wraps modulo 2^32.
    target   = ex.NPC + {ex.Imm_Ext[29:0], 2'b00};
    case (ex.JumpSel)
      JSEL_J: begin
        redirect = 1'b1;
        target   = ex.JumpAddr;
      end
      JSEL_JR: begin
        redirect = 1'b1;
        target   = ex.port_a;
      end
      JSEL_SEQ: redirect = (ex.BEQ & ex.zero) | (ex.BNE & ~ex.zero);
      default:  redirect = 1'b0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM latch, data-memory request with stall until
// dhit, branch/jump redirect with flush, and the registered MEM/WB latch.
import custom_types_pkg::*;

module memory_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  execute_t               ex_in,
  input  logic                   ex_valid,
  input  logic                   dhit,
  input  logic [31:0]            dmemload,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic [31:0]            dmemaddr,
  output logic [31:0]            dmemstore,
  output logic                   mem_stall,
  output logic                   pc_redirect,
  output logic [31:0]            pc_target,
  output logic                   flush,
  output memory_t                mem_out,
  output logic                   mem_valid,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output mem_state_t             memState
);

  execute_t    exm;
  logic        exmV;
  mem_state_t  state, stateNext;
  logic        isHalted, acc, wbHalt;
  logic        brRedirect, redirect;
  logic [31:0] brTarget;

  branch_resolve uBranch (
    .ex       (exm),
    .redirect (brRedirect),
    .target   (brTarget)
  );

  // Request handshake: dmemREN/dmemWEN act as valid, dhit as ready. The
  // request is driven from the frozen EX/MEM latch, so it stays stable until
  // the cycle dhit is seen; that cycle completes the transfer.
  assign isHalted  = (state == HALTED);
  assign acc       = exmV & (exm.dREN | exm.dWEN) & ~isHalted;
  assign dmemREN   = acc & exm.dREN;
  assign dmemWEN   = acc & exm.dWEN & ~exm.dREN;
  assign dmemaddr  = exm.port_o;
  assign dmemstore = exm.port_b;
  assign mem_stall = (acc & ~dhit) | isHalted;

  assign redirect    = exmV & ~isHalted & brRedirect;
  assign pc_redirect = redirect;
  assign flush       = redirect;
  assign pc_target   = redirect ? brTarget : 32'h0;

  assign wbHalt   = ~mem_stall & exmV & exm.halt;
  assign halted   = isHalted;
  assign memState = state;

  always_comb begin
    stateNext = state;
    if (!isHalted && wbHalt) begin
      stateNext = HALTED;
    end else begin
      case (state)
        IDLE:    if (acc && !dhit) stateNext = WAIT;
        WAIT:    if (dhit) stateNext = IDLE;
        HALTED:  stateNext = HALTED;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      exm          <= '0;
      exmV         <= 1'b0;
      mem_out      <= '0;
      mem_valid    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= stateNext;

      if (!mem_stall) begin
        if (flush) begin
          exm  <= '0;
          exmV <= 1'b0;
        end else begin
          exm  <= ex_in;
          exmV <= ex_valid;
        end
      end

      if (mem_stall) begin
        mem_out   <= '0;
        mem_valid <= 1'b0;
      end else begin
        mem_out.Rw       <= exm.Rw;
        mem_out.RegWEN   <= exm.RegWEN & exmV;
        mem_out.MemtoReg <= exm.MemtoReg;
        mem_out.halt     <= exm.halt & exmV;
        mem_out.NPC      <= exm.NPC;
        mem_out.port_o   <= exm.port_o;
        mem_out.Imm_Ext  <= exm.Imm_Ext;
        mem_out.dmemload <= (acc && dhit) ? dmemload : 32'h0;
        mem_valid        <= exmV;
      end

      if (mem_stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads with wait states, stores, branches,
// jumps, halt absorption and reset in the middle of a pending load.
import custom_types_pkg::*;

module tb_memory_stage;

  logic        CLK = 1'b0;
  logic        RST;
  execute_t    ex_in;
  logic        ex_valid;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mem_stall, pc_redirect, flush, mem_valid, halted;
  logic [31:0] dmemaddr, dmemstore, pc_target;
  memory_t     mem_out;
  logic [15:0] stall_cycles;
  mem_state_t  memState;

  int total = 0;
  int bad   = 0;

  memory_stage #(.STALL_CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .ex_in(ex_in), .ex_valid(ex_valid), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .flush(flush),
    .mem_out(mem_out), .mem_valid(mem_valid), .halted(halted),
    .stall_cycles(stall_cycles), .memState(memState)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // instruction builders
  function automatic execute_t mkLw(input logic [31:0] addr, input logic [4:0] rw);
    execute_t e = '0;
    e.dREN = 1'b1; e.port_o = addr; e.RegWEN = 1'b1; e.Rw = rw; e.MemtoReg = MTR_MEM;
    return e;
  endfunction

  function automatic execute_t mkSw(input logic [31:0] addr, input logic [31:0] data);
    execute_t e = '0;
    e.dWEN = 1'b1; e.port_o = addr; e.port_b = data;
    return e;
  endfunction

  function automatic execute_t mkBr(input logic beq, input logic bne, input logic zero,
                                    input logic [31:0] npc, input logic [31:0] imm);
    execute_t e = '0;
    e.JumpSel = JSEL_SEQ; e.BEQ = beq; e.BNE = bne; e.zero = zero; e.NPC = npc; e.Imm_Ext = imm;
    return e;
  endfunction

  task automatic test_reset();
    RST = 1'b1; ex_in = '0; ex_valid = 1'b0; dhit = 1'b0; dmemload = '0;
    cycle(); cycle();
    RST = 1'b0;
    #1;
    total++; if (mem_out !== '0) begin bad++; $display("FAIL reset_mem_out got=%h want=0", mem_out); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b want=0", mem_valid); end
    total++; if ({dmemREN, dmemWEN, mem_stall, pc_redirect, flush, halted} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {dmemREN, dmemWEN, mem_stall, pc_redirect, flush, halted}); end
    total++; if (pc_target !== 32'h0) begin bad++; $display("FAIL reset_pc_target got=%h want=0", pc_target); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall_cycles got=%0d want=0", stall_cycles); end
    total++; if (memState !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", memState, IDLE); end
    cycle();
  endtask

  task automatic test_load();
    int renCnt = 0;
    ex_in = mkLw(32'h100, 5'd5); ex_valid = 1'b1; dhit = 1'b0;
    cycle();
    ex_in = '0; ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dmemREN === 1'b1) renCnt++;
      total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL lw_stall[%0d] got=%b want=1", i, mem_stall); end
      total++; if (dmemaddr !== 32'h100) begin bad++; $display("FAIL lw_addr[%0d] got=%h want=100", i, dmemaddr); end
      if (i == 1) begin
        total++; if (memState !== WAIT) begin bad++; $display("FAIL lw_state got=%0d want=%0d", memState, WAIT); end
      end
      cycle();
    end
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    #1;
    if (dmemREN === 1'b1) renCnt++;
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL lw_hit_stall got=%b want=0", mem_stall); end
    total++; if (dmemWEN !== 1'b0) begin bad++; $display("FAIL lw_wen got=%b want=0", dmemWEN); end
    cycle();
    dhit = 1'b0; dmemload = '0;
    #1;
    total++; if (renCnt != 4) begin bad++; $display("FAIL lw_ren_cycles got=%0d want=4", renCnt); end
    total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL lw_ren_drop got=%b want=0", dmemREN); end
    total++; if (mem_out.dmemload !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", mem_out.dmemload); end
    total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%b want=1", mem_valid); end
    total++; if ({mem_out.RegWEN, mem_out.Rw, mem_out.MemtoReg} !== {1'b1, 5'd5, MTR_MEM}) begin
      bad++; $display("FAIL lw_wb_fields got=%b want=%b", {mem_out.RegWEN, mem_out.Rw, mem_out.MemtoReg}, {1'b1, 5'd5, MTR_MEM}); end
    total++; if (stall_cycles !== 16'd3) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=3", stall_cycles); end
    cycle();
  endtask

  task automatic test_store();
    ex_in = mkSw(32'h40, 32'h1234); ex_valid = 1'b1;
    cycle();
    ex_in = '0; ex_valid = 1'b0; dhit = 1'b1;
    #1;
    total++; if ({dmemWEN, dmemREN, mem_stall} !== 3'b100) begin
      bad++; $display("FAIL sw_ctrl got=%b want=100", {dmemWEN, dmemREN, mem_stall}); end
    total++; if (dmemstore !== 32'h1234) begin bad++; $display("FAIL sw_store got=%h want=1234", dmemstore); end
    total++; if (dmemaddr !== 32'h40) begin bad++; $display("FAIL sw_addr got=%h want=40", dmemaddr); end
    cycle();
    dhit = 1'b0;
    #1;
    total++; if (dmemWEN !== 1'b0) begin bad++; $display("FAIL sw_wen_drop got=%b want=0", dmemWEN); end
    total++; if ({mem_valid, mem_out.RegWEN} !== 2'b10) begin bad++; $display("FAIL sw_wb got=%b want=10", {mem_valid, mem_out.RegWEN}); end
    total++; if (stall_cycles !== 16'd3) begin bad++; $display("FAIL sw_stall_cycles got=%0d want=3", stall_cycles); end
    cycle();
  endtask

  task automatic test_branch();
    ex_in = mkBr(1'b1, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFE); ex_valid = 1'b1;
    cycle();
    ex_in = mkLw(32'h500, 5'd7); ex_valid = 1'b1;
    #1;
    total++; if ({pc_redirect, flush} !== 2'b11) begin bad++; $display("FAIL beq_redirect got=%b want=11", {pc_redirect, flush}); end
    total++; if (pc_target !== 32'h18) begin bad++; $display("FAIL beq_target got=%h want=18", pc_target); end
    cycle();
    ex_in = '0; ex_valid = 1'b0;
    #1;
    total++; if ({pc_redirect, dmemREN} !== 2'b00) begin bad++; $display("FAIL beq_pulse got=%b want=00", {pc_redirect, dmemREN}); end
    total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL beq_wb_valid got=%b want=1", mem_valid); end
    cycle();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL beq_squash got=%b want=0", mem_valid); end

    ex_in = mkBr(1'b0, 1'b1, 1'b1, 32'h20, 32'h4); ex_valid = 1'b1;
    cycle();
    ex_in = '0; ex_valid = 1'b0;
    #1;
    total++; if ({pc_redirect, flush} !== 2'b00) begin bad++; $display("FAIL bne_redirect got=%b want=00", {pc_redirect, flush}); end
    cycle();

    ex_in = '0; ex_in.JumpSel = JSEL_JR; ex_in.port_a = 32'h400; ex_valid = 1'b1;
    cycle();
    ex_in = '0; ex_valid = 1'b0;
    #1;
    total++; if ({pc_redirect, pc_target} !== {1'b1, 32'h400}) begin
      bad++; $display("FAIL jr_target got=%b/%h want=1/400", pc_redirect, pc_target); end
    cycle();

    ex_in = '0; ex_in.JumpSel = JSEL_J; ex_in.JumpAddr = 32'h80; ex_in.port_a = 32'h999; ex_valid = 1'b1;
    cycle();
    ex_in = '0; ex_valid = 1'b0;
    #1;
    total++; if ({pc_redirect, pc_target} !== {1'b1, 32'h80}) begin
      bad++; $display("FAIL j_target got=%b/%h want=1/80", pc_redirect, pc_target); end
    cycle();
  endtask

  task automatic test_halt();
    ex_in = '0; ex_in.halt = 1'b1; ex_valid = 1'b1;
    cycle();
    ex_in = mkLw(32'h200, 5'd3); ex_valid = 1'b1;
    #1;
    total++; if ({halted, mem_stall} !== 2'b00) begin bad++; $display("FAIL halt_pre got=%b want=00", {halted, mem_stall}); end
    cycle();
    ex_in = '0; ex_valid = 1'b0;
    #1;
    total++; if ({halted, mem_out.halt, mem_valid} !== 3'b111) begin
      bad++; $display("FAIL halt_latched got=%b want=111", {halted, mem_out.halt, mem_valid}); end
    for (int i = 0; i < 5; i++) begin
      total++; if ({dmemREN, mem_stall, halted} !== 3'b011) begin
        bad++; $display("FAIL halt_hold[%0d] got=%b want=011", i, {dmemREN, mem_stall, halted}); end
      dhit = (i == 2);
      cycle();
    end
    dhit = 1'b0;
    total++; if ({mem_valid, mem_out.halt, mem_out.RegWEN} !== 3'b000) begin
      bad++; $display("FAIL halt_bubble got=%b want=000", {mem_valid, mem_out.halt, mem_out.RegWEN}); end
    total++; if (memState !== HALTED) begin bad++; $display("FAIL halt_state got=%0d want=%0d", memState, HALTED); end
  endtask

  task automatic test_reset_wait();
    RST = 1'b1; cycle(); RST = 1'b0; cycle();
    ex_in = mkLw(32'h300, 5'd9); ex_valid = 1'b1; dhit = 1'b0;
    cycle();
    ex_in = '0; ex_valid = 1'b0;
    total++; if (dmemREN !== 1'b1) begin bad++; $display("FAIL rw_req got=%b want=1", dmemREN); end
    cycle();
    total++; if ({memState == WAIT, dmemREN} !== 2'b11) begin
      bad++; $display("FAIL rw_wait got=%0d/%b want=%0d/1", memState, dmemREN, WAIT); end
    RST = 1'b1;
    cycle();
    total++; if ({dmemREN, mem_stall, mem_valid} !== 3'b000) begin
      bad++; $display("FAIL rw_drop got=%b want=000", {dmemREN, mem_stall, mem_valid}); end
    total++; if (memState !== IDLE) begin bad++; $display("FAIL rw_state got=%0d want=%0d", memState, IDLE); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rw_stall_clr got=%0d want=0", stall_cycles); end
    RST = 1'b0; dhit = 1'b1; dmemload = 32'hCAFEF00D;
    #1;
    total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL rw_late_ren got=%b want=0", dmemREN); end
    cycle();
    dhit = 1'b0; dmemload = '0;
    total++; if ({mem_valid, mem_out.dmemload} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL rw_late_hit got=%b/%h want=0/0", mem_valid, mem_out.dmemload); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rw_late_stall got=%0d want=0", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_halt();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
